// File: rtl/matmul_ctrl.sv
// matmul_ctrl -- sequencer for a 16-lane matrix-multiply datapath.
//
// Purpose:
//    Holds a small operand buffer (activation row + weight byte per entry),
//    streams K entries to the datapath as consecutive beats, waits for the
//    datapath result, captures it and hands it to a consumer with a
//    valid/ready handshake. Illegal requests and result timeouts raise a
//    one-cycle err_o pulse; abort_i cancels a running job silently.
//
// Ports:
//    clk_i, rstn_i          clock, asynchronous active-low reset
//    wr_en_i/wr_addr_i/     buffer load port (honoured only while idle)
//    wr_din_i/wr_win_i
//    start_i, k_len_i       job request and beat count (1..DEPTH)
//    abort_i                cancel the running job
//    mm_en_o, mm_valid_o    datapath enable / operand beat valid
//    mm_din_o, mm_win_o     operand beat (activations, weight)
//    mm_vld_i, mm_result_i  datapath result return
//    busy_o                 a job is in progress
//    done_o, err_o          one-cycle completion / error pulses
//    res_valid_o/res_ready_i/res_data_o   captured result handshake
module matmul_ctrl #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         wr_en_i,
   input  logic [3:0]   wr_addr_i,
   input  logic [127:0] wr_din_i,
   input  logic [7:0]   wr_win_i,
   input  logic         start_i,
   input  logic [4:0]   k_len_i,
   input  logic         abort_i,
   output logic         mm_en_o,
   output logic         mm_valid_o,
   output logic [127:0] mm_din_o,
   output logic [7:0]   mm_win_o,
   input  logic         mm_vld_i,
   input  logic [511:0] mm_result_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         err_o,
   output logic         res_valid_o,
   input  logic         res_ready_i,
   output logic [511:0] res_data_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int KW = $clog2(DEPTH + 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, FEED, WAIT, OUT} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   beat_q, beat_d;
   logic [KW-1:0]   k_q, k_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            err_q, err_d;
   logic            done_q, done_d;
   logic [511:0]    res_q, res_d;
   logic [135:0]    rd_q, rd_d;

   logic [135:0]    buf_mem [DEPTH];
   logic            wr_ok;
   logic [AW-1:0]   wr_idx;
   logic            rd_load;
   logic [AW-1:0]   rd_addr;
   logic            k_ok;
   logic            last_beat;

   assign wr_idx    = AW'(wr_addr_i);
   assign k_ok      = (k_len_i != 5'd0) && (32'(k_len_i) <= 32'(DEPTH));
   assign last_beat = (KW'(beat_q) + KW'(1)) == k_q;

   // Operand buffer: plain array, written only while idle. No reset so it
   // can map onto block RAM.
   always_ff @(posedge clk_i) begin
      if (wr_ok) begin
         buf_mem[wr_idx] <= {wr_din_i, wr_win_i};
      end
   end

   always_comb begin
      rd_d = buf_mem[rd_addr];
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      k_d     = k_q;
      tmo_d   = tmo_q;
      err_d   = 1'b0;
      done_d  = 1'b0;
      res_d   = res_q;
      rd_load = 1'b0;
      rd_addr = '0;
      wr_ok   = 1'b0;

      case (state_q)
         IDLE: begin
            wr_ok = wr_en_i;
            if (start_i) begin
               if (k_ok) begin
                  // Entry 0 is fetched on the accept edge so beat 0 is on
                  // the bus in the very first FEED cycle.
                  k_d     = KW'(k_len_i);
                  beat_d  = '0;
                  rd_load = 1'b1;
                  rd_addr = '0;
                  state_d = FEED;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FEED: begin
            if (last_beat) begin
               tmo_d   = '0;
               state_d = WAIT;
            end else begin
               // Prefetch the next entry while the current beat is shown.
               beat_d  = beat_q + AW'(1);
               rd_load = 1'b1;
               rd_addr = beat_q + AW'(1);
            end
         end
         WAIT: begin
            if (mm_vld_i) begin
               res_d   = mm_result_i;
               state_d = OUT;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         OUT: begin
            if (res_ready_i) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Buffer writes are refused while a job owns the buffer.
      if (state_q != IDLE && wr_en_i) begin
         err_d = 1'b1;
      end

      // Abort wins over everything else in the same cycle and is silent.
      if (state_q != IDLE && abort_i) begin
         state_d = IDLE;
         err_d   = 1'b0;
         done_d  = 1'b0;
         res_d   = res_q;
         rd_load = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         beat_q  <= '0;
         k_q     <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         k_q     <= k_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         done_q  <= done_d;
         res_q   <= res_d;
         if (rd_load) begin
            rd_q <= rd_d;
         end
      end
   end

   assign mm_en_o     = (state_q == FEED) || (state_q == WAIT);
   assign mm_valid_o  = (state_q == FEED);
   assign mm_din_o    = rd_q[135:8];
   assign mm_win_o    = rd_q[7:0];
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign res_valid_o = (state_q == OUT);
   assign res_data_o  = res_q;

endmodule

// File: tb/tb_matmul_ctrl.sv
// tb_matmul_ctrl -- scoreboard bench for matmul_ctrl.
// Stimulus pushes expected beats, results and err/done events into queues;
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_matmul_ctrl;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 64;

   logic         clk = 1'b0;
   logic         rstn_i = 1'b0;
   logic         wr_en_i = 1'b0;
   logic [3:0]   wr_addr_i = '0;
   logic [127:0] wr_din_i = '0;
   logic [7:0]   wr_win_i = '0;
   logic         start_i = 1'b0;
   logic [4:0]   k_len_i = '0;
   logic         abort_i = 1'b0;
   logic         mm_en_o, mm_valid_o;
   logic [127:0] mm_din_o;
   logic [7:0]   mm_win_o;
   logic         mm_vld_i = 1'b0;
   logic [511:0] mm_result_i = '0;
   logic         busy_o, done_o, err_o, res_valid_o;
   logic         res_ready_i = 1'b0;
   logic [511:0] res_data_o;

   matmul_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rstn_i(rstn_i),
      .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_din_i(wr_din_i), .wr_win_i(wr_win_i),
      .start_i(start_i), .k_len_i(k_len_i), .abort_i(abort_i),
      .mm_en_o(mm_en_o), .mm_valid_o(mm_valid_o), .mm_din_o(mm_din_o), .mm_win_o(mm_win_o),
      .mm_vld_i(mm_vld_i), .mm_result_i(mm_result_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model of the operand buffer and expectation queues.
   logic [135:0] model [DEPTH];
   logic [135:0] beat_exp [$];
   logic [511:0] res_exp  [$];
   byte          evt_exp  [$];
   logic [511:0] last_res = '0;

   task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   initial begin : monitor
      logic         prev_rv;
      logic [511:0] cur_res;
      logic [135:0] b;
      byte          e;
      prev_rv = 1'b0;
      cur_res = '0;
      forever begin
         @(negedge clk);
         if (mm_valid_o) begin
            if (beat_exp.size() == 0) check("extra_beat", 1, 0);
            else begin
               b = beat_exp.pop_front();
               check("beat", {mm_din_o, mm_win_o}, b);
            end
         end
         if (res_valid_o) begin
            if (!prev_rv) begin
               if (res_exp.size() == 0) check("unexpected_res_valid", 1, 0);
               else cur_res = res_exp.pop_front();
            end
            check("res_data", res_data_o, cur_res);
         end
         prev_rv = res_valid_o;
         if (err_o) begin
            if (evt_exp.size() == 0) check("unexpected_err", 1, 0);
            else begin
               e = evt_exp.pop_front();
               check("err_event", "E", e);
            end
         end
         if (done_o) begin
            if (evt_exp.size() == 0) check("unexpected_done", 1, 0);
            else begin
               e = evt_exp.pop_front();
               check("done_event", "D", e);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic load(input int a, input logic [127:0] din, input logic [7:0] win);
      wr_en_i = 1'b1; wr_addr_i = 4'(a); wr_din_i = din; wr_win_i = win;
      tick();
      wr_en_i = 1'b0;
      model[a] = {din, win};
   endtask

   task automatic load_random(input int n);
      for (int i = 0; i < n; i++) load(i, rnd512()[127:0], 8'($urandom));
   endtask

   // Issue a job and return in the first WAIT cycle. mm_vld_i is toggled
   // randomly during FEED and must be ignored there.
   task automatic start_job(input int k, input bit wr_mid);
      for (int i = 0; i < k; i++) beat_exp.push_back(model[i]);
      start_i = 1'b1; k_len_i = 5'(k);
      tick();
      start_i = 1'b0;
      check("feed_first_valid", {busy_o, mm_en_o, mm_valid_o}, 3'b111);
      for (int i = 0; i < k; i++) begin
         mm_vld_i = 1'($urandom);
         mm_result_i = rnd512();
         if (wr_mid && i == 1) begin
            wr_en_i = 1'b1; wr_addr_i = 4'd1;
            wr_din_i = rnd512()[127:0]; wr_win_i = 8'($urandom);
            evt_exp.push_back("E");
         end
         tick();
         wr_en_i = 1'b0;
      end
      mm_vld_i = 1'b0;
      check("wait_entry", {busy_o, mm_en_o, mm_valid_o}, 3'b110);
   endtask

   task automatic finish_job(input int d, input int bp, input logic [511:0] res);
      repeat (d) tick();
      mm_vld_i = 1'b1; mm_result_i = res;
      res_exp.push_back(res);
      last_res = res;
      tick();
      mm_vld_i = 1'b0; mm_result_i = rnd512();
      check("res_valid_next", res_valid_o, 1);
      repeat (bp) tick();
      res_ready_i = 1'b1;
      evt_exp.push_back("D");
      tick();
      res_ready_i = 1'b0;
      check("done_pulse", {done_o, busy_o, res_valid_o}, 3'b100);
      tick();
      check("done_single", done_o, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin : stim
      repeat (2) tick();
      check("rst_ctrl", {busy_o, mm_en_o, mm_valid_o, done_o, err_o, res_valid_o}, 0);
      check("rst_res_data", res_data_o, 0);
      check("rst_operand", {mm_din_o, mm_win_o}, 0);
      rstn_i = 1'b1;
      tick();

      // Normal job with index-pattern entries and an A5 result.
      for (int i = 0; i < 4; i++) load(i, {16{8'(i)}}, 8'd2);
      start_job(4, 1'b0);
      finish_job(2, 0, {64{8'hA5}});

      // Back-pressure: consumer stalls for 10 cycles.
      load_random(6);
      start_job(6, 1'b0);
      finish_job(0, 10, rnd512());

      // Illegal start lengths.
      for (int j = 0; j < 2; j++) begin
         start_i = 1'b1; k_len_i = (j == 0) ? 5'd0 : 5'd17;
         evt_exp.push_back("E");
         tick();
         start_i = 1'b0;
         check("bad_start_err", {err_o, busy_o}, 2'b10);
         tick();
         check("bad_start_idle", {err_o, busy_o}, 2'b00);
      end

      // Abort while idle does nothing.
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("idle_abort", {busy_o, err_o, done_o}, 0);

      // Write during FEED is refused; a re-run shows identical beats.
      load_random(4);
      start_job(4, 1'b1);
      finish_job(1, 1, rnd512());
      start_job(4, 1'b0);
      finish_job(0, 0, rnd512());

      // Timeout: no result ever arrives.
      start_job(1, 1'b0);
      evt_exp.push_back("E");
      repeat (TIMEOUT - 1) tick();
      check("tmo_not_yet", {err_o, mm_en_o, busy_o}, 3'b011);
      tick();
      check("tmo_err", {err_o, mm_en_o, busy_o, res_valid_o}, 4'b1000);
      tick();
      check("tmo_err_single", err_o, 0);

      // Abort on beat 2 of 8.
      load_random(8);
      for (int i = 0; i < 3; i++) beat_exp.push_back(model[i]);
      start_i = 1'b1; k_len_i = 5'd8;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check("abort_feed", {busy_o, mm_en_o, mm_valid_o}, 0);
      repeat (3) tick();

      // Abort together with mm_vld_i: no capture.
      start_job(2, 1'b0);
      tick();
      abort_i = 1'b1; mm_vld_i = 1'b1; mm_result_i = rnd512();
      tick();
      abort_i = 1'b0; mm_vld_i = 1'b0;
      check("abort_vld_idle", {busy_o, res_valid_o, mm_en_o}, 0);
      check("abort_no_capture", res_data_o, last_res);
      repeat (3) tick();

      // Randomised jobs.
      for (int n = 0; n < 6; n++) begin
         int k;
         k = $urandom_range(1, DEPTH);
         load_random(k);
         start_job(k, 1'b0);
         finish_job($urandom_range(0, 8), $urandom_range(0, 5), rnd512());
      end

      // Reset during WAIT clears outputs asynchronously.
      load_random(3);
      start_job(3, 1'b0);
      tick();
      #2 rstn_i = 1'b0;
      #1;
      check("async_rst_ctrl", {busy_o, mm_en_o, mm_valid_o, done_o, err_o, res_valid_o}, 0);
      check("async_rst_res", res_data_o, 0);
      check("async_rst_operand", {mm_din_o, mm_win_o}, 0);
      tick();
      rstn_i = 1'b1;
      tick();

      // Fresh job after reset.
      load_random(5);
      start_job(5, 1'b0);
      finish_job(3, 2, rnd512());

      repeat (5) tick();
      check("beats_left", beat_exp.size(), 0);
      check("results_left", res_exp.size(), 0);
      check("events_left", evt_exp.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/matmul_ctrl.md
MATMUL_CTRL -- requirements
Module: matmul_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning operand buffer entries and maximum job length K.
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning maximum WAIT cycles before a job is abandoned.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk_i  in  1  rising-edge clock; rstn_i  in  1  async active-low reset.
REQ-004 SHALL have these load ports: wr_en_i  in  1  buffer write strobe; wr_addr_i  in  4  entry index; wr_din_i  in  128  16 x 8-bit activation bytes; wr_win_i  in  8  weight byte.
REQ-005 SHALL have these control ports: start_i  in  1  job request; k_len_i  in  5  beat count 1..DEPTH; abort_i  in  1  cancel current job.
REQ-006 SHALL have these datapath drive ports: mm_en_o  out  1  datapath enable; mm_valid_o  out  1  operand beat valid; mm_din_o  out  128  activations; mm_win_o  out  8  weight.
REQ-007 SHALL have these datapath return ports: mm_vld_i  in  1  result valid; mm_result_i  in  512  16 x 32-bit results.
REQ-008 SHALL have these status ports: busy_o  out  1  state != IDLE; done_o  out  1  job-complete pulse; err_o  out  1  error pulse; res_valid_o  out  1  result held; res_ready_i  in  1  result consumer ready; res_data_o  out  512  captured result.

Function
REQ-009 SHALL store {wr_din_i, wr_win_i} to entry wr_addr_i on a cycle where wr_en_i=1 and state=IDLE.
REQ-010 SHALL ignore wr_en_i outside IDLE, leave the buffer unchanged, and pulse err_o for 1 cycle.
REQ-011 SHALL implement the FSM states IDLE, FEED, WAIT and OUT.
REQ-012 SHALL, in IDLE, accept start_i=1 only with 1<=k_len_i<=DEPTH, latch K and go to FEED.
REQ-013 SHALL, in IDLE, reject start_i=1 with k_len_i=0 or k_len_i>DEPTH: stay IDLE and pulse err_o for 1 cycle.
REQ-014 SHALL ignore start_i in every state other than IDLE.
REQ-015 SHALL, in FEED, drive beat i (i=0..K-1) at cycle T+1+i, where T is the accept cycle: mm_en_o=1, mm_valid_o=1, mm_din_o/mm_win_o = entry i.
REQ-016 SHALL exit FEED after beat K-1 and enter WAIT.
REQ-017 SHALL, in WAIT, hold mm_en_o=1 and mm_valid_o=0.
REQ-018 SHALL ignore mm_vld_i during FEED.
REQ-019 SHALL, in WAIT, capture mm_result_i into res_data_o on the cycle mm_vld_i=1 is sampled, assert res_valid_o on the next cycle and enter OUT.
REQ-020 SHALL, in WAIT, pulse err_o, deassert mm_en_o and return to IDLE after TIMEOUT cycles without mm_vld_i; res_valid_o stays 0.
REQ-021 SHALL, in OUT, hold res_valid_o=1 and keep res_data_o stable until res_valid_o and res_ready_i are both 1.
REQ-022 SHALL, on the cycle after that OUT handshake, deassert res_valid_o, pulse done_o for 1 cycle and return to IDLE.
REQ-023 SHALL hold mm_en_o=0 and mm_valid_o=0 in IDLE; mm_en_o=0 is the datapath accumulator clear.
REQ-024 SHALL, on abort_i=1 in any non-IDLE state, enter IDLE on the next cycle with mm_en_o, mm_valid_o and res_valid_o =0, no done_o and no err_o.
REQ-025 SHALL give abort_i priority over mm_vld_i, the timeout and res_ready_i when they occur in the same cycle.
REQ-026 SHALL treat abort_i in IDLE as a no-op.
REQ-027 SHALL keep the beat counter and the timeout counter narrow enough for DEPTH and TIMEOUT, with no wrap-around inside a job.
REQ-028 SHALL drive busy_o=1 in FEED, WAIT and OUT.

Reset
REQ-029 SHALL, while rstn_i=0 asynchronously, put the FSM in IDLE and drive every output and counter to 0, including res_data_o, mm_din_o and mm_win_o.
REQ-030 SHALL NOT require buffer contents to be reset; they are undefined after reset.
REQ-031 SHALL, on reset mid-job, abandon the job with no done_o and no err_o.

Verification
REQ-032 SHALL cover normal job: load entries 0..3 with wr_din_i=entry index replicated, weight=2; start k_len=4 -> mm_valid_o high for exactly 4 cycles from T+1 with entries 0..3 in order; mm_vld_i with result 0xA5 pattern -> res_valid_o next cycle with data=0xA5 pattern; res_ready_i=1 -> done_o 1-cycle pulse, busy_o=0.
REQ-033 SHALL cover back-pressure: res_ready_i=0 for 10 cycles -> res_valid_o and res_data_o stable throughout; release -> single done_o.
REQ-034 SHALL cover illegal requests: start with k_len=0 and k_len=17 -> err_o pulses, busy_o stays 0; wr_en_i during FEED -> err_o, buffer unchanged (re-run job, same beats).
REQ-035 SHALL cover timeout: start k_len=1, never assert mm_vld_i -> err_o exactly TIMEOUT cycles after WAIT entry, mm_en_o=0, res_valid_o never 1.
REQ-036 SHALL cover abort and simultaneity: abort_i on beat 2 of 8 -> IDLE next cycle, no done_o; abort_i in the same cycle as mm_vld_i -> no capture, res_valid_o stays 0.
REQ-037 SHALL cover reset mid-job: rstn_i low during WAIT -> all outputs 0 immediately (asynchronously); a new job after reset completes normally.
